// File: rtl/keypad_digit_entry.sv
// keypad_digit_entry
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces the
//   row pattern, and shifts accepted decimal digits into a four-digit BCD
//   entry buffer. '*' is backspace, '#' clears the buffer, and A-D only
//   report a key code.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   row_in     keypad rows, active-low, asynchronous to clk
//   col_out    column drive, active-low one-hot
//   key_valid  one-cycle pulse per accepted press
//   key_code   code of the last accepted key (held between presses)
//   digit3..0  BCD entry buffer, digit3 most significant
module keypad_digit_entry #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  state_e         state_q, state_d;
  logic [3:0]     row_meta_q, row_s_q;
  logic [DivW-1:0] div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]     pattern_q, pattern_d;
  logic [3:0]     col_q, col_d;
  logic           key_valid_q, key_valid_d;
  logic [3:0]     key_code_q, key_code_d;
  logic [15:0]    digits_q, digits_d;
  logic           tick;
  logic           accept;
  logic [1:0]     row_idx, col_idx;
  logic [3:0]     code;

  assign tick = (div_q == DivW'(SCAN_DIV - 1));

  // Lowest-index low row wins when several rows are low.
  always_comb begin
    row_idx = 2'd3;
    if (!pattern_q[2]) row_idx = 2'd2;
    if (!pattern_q[1]) row_idx = 2'd1;
    if (!pattern_q[0]) row_idx = 2'd0;
  end

  always_comb begin
    col_idx = 2'd0;
    unique case (col_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  always_comb begin
    code = 4'd0;
    case ({row_idx, col_idx})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      default: code = 4'd13;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + 1'b1;
    cnt_d       = cnt_q;
    pattern_d   = pattern_q;
    col_d       = col_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    digits_d    = digits_q;
    accept      = 1'b0;

    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (row_s_q == 4'hF) begin
            col_d = {col_q[2:0], col_q[3]};
          end else begin
            pattern_d = row_s_q;
            cnt_d     = CntW'(1);
            state_d   = StDebounce;
          end
        end
        StDebounce: begin
          if (row_s_q == pattern_q) begin
            if (cnt_q == CntW'(DEBOUNCE - 1)) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = StHeld;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            col_d   = {col_q[2:0], col_q[3]};
            state_d = StScan;
          end
        end
        StHeld: begin
          // Any low sample restarts the release count.
          if (row_s_q == 4'hF) begin
            if (cnt_q == CntW'(DEBOUNCE - 1)) begin
              cnt_d   = '0;
              col_d   = {col_q[2:0], col_q[3]};
              state_d = StScan;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = StScan;
      endcase
    end

    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = code;
      if (code <= 4'd9) begin
        digits_d = {digits_q[11:0], code};
      end else if (code == 4'd14) begin
        digits_d = {4'd0, digits_q[15:4]};
      end else if (code == 4'd15) begin
        digits_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StScan;
      row_meta_q  <= '0;
      row_s_q     <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      pattern_q   <= '0;
      col_q       <= 4'b1110;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      digits_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_meta_q  <= row_in;
      row_s_q     <= row_meta_q;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      pattern_q   <= pattern_d;
      col_q       <= col_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      digits_q    <= digits_d;
    end
  end

  assign col_out   = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digit3    = digits_q[15:12];
  assign digit2    = digits_q[11:8];
  assign digit1    = digits_q[7:4];
  assign digit0    = digits_q[3:0];

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Bench for keypad_digit_entry: a keypad model drives the rows from col_out,
// expected {key_code, digits} are queued per press and popped on key_valid.
module tb_keypad_digit_entry;

  logic       clk;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit3, digit2, digit1, digit0;

  int total = 0;
  int bad   = 0;

  logic [19:0] exp_q[$];
  logic [15:0] ed;
  logic [3:0]  kmap [16];

  // Keypad model
  logic       key_on;
  int         key_r, key_c;
  logic       raw_on;
  logic [3:0] raw_val;

  keypad_digit_entry #(
    .SCAN_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_valid(key_valid),
    .key_code (key_code),
    .digit3   (digit3),
    .digit2   (digit2),
    .digit1   (digit1),
    .digit0   (digit0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    if (raw_on) begin
      row_in = raw_val;
    end else if (key_on && (col_out[key_c] == 1'b0)) begin
      row_in[key_r] = 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_key_valid", 32'd1, 32'd0);
      end else begin
        check_val("key_result", {12'd0, key_code, digit3, digit2, digit1, digit0},
                  {12'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [15:0] apply(input logic [15:0] d, input logic [3:0] code);
    if (code <= 4'd9) return {d[11:0], code};
    if (code == 4'd14) return {4'd0, d[15:4]};
    if (code == 4'd15) return 16'd0;
    return d;
  endfunction

  task automatic press(input int r, input int c, input int hold);
    logic [3:0] code;
    logic [3:0] col_exp;
    code = kmap[r*4+c];
    ed = apply(ed, code);
    exp_q.push_back({code, ed});
    key_r = r;
    key_c = c;
    key_on = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    col_exp = 4'b1111;
    col_exp[c] = 1'b0;
    check_val("frozen_col", {28'd0, col_out}, {28'd0, col_exp});
    key_on = 1'b0;
    repeat (30) @(posedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_col"}, {28'd0, col_out}, 32'hE);
    check_val({tag, "_kv"}, {31'd0, key_valid}, 32'd0);
    check_val({tag, "_out"}, {12'd0, key_code, digit3, digit2, digit1, digit0}, 32'd0);
  endtask

  initial begin
    logic [3:0] col_prev;
    logic       found;
    kmap = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6, 4'd11,
             4'd7, 4'd8, 4'd9, 4'd12, 4'd14, 4'd0, 4'd15, 4'd13};
    ed = 16'd0;
    key_on = 1'b0;
    key_r = 0;
    key_c = 0;
    raw_on = 1'b0;
    raw_val = 4'hF;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("post_reset");

    // Single digit 5 (row1, col1)
    press(1, 1, 40);
    check_val("q_single", exp_q.size(), 0);

    // Digit sequence 1..5 -> 2345
    press(0, 0, 40);
    press(0, 1, 40);
    press(0, 2, 40);
    press(1, 0, 40);
    press(1, 1, 40);
    check_val("seq_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h2345);

    // Bounce: row0 low for exactly one tick's worth of cycles
    raw_val = 4'b1110;
    raw_on = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    raw_on = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    col_prev = col_out;
    repeat (4) @(posedge clk);
    #1;
    check_val("bounce_rotates", {31'd0, col_out != col_prev}, 32'd1);
    check_val("q_bounce", exp_q.size(), 0);

    // Long hold of key 5: exactly one pulse
    press(1, 1, 160);

    // Backspace and clear
    press(3, 2, 40);
    press(0, 0, 40);
    press(0, 1, 40);
    press(0, 2, 40);
    press(1, 0, 40);
    press(3, 0, 40);
    check_val("bksp_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0123);
    check_val("bksp_code", {28'd0, key_code}, 32'd14);
    press(3, 2, 40);
    check_val("clear_code", {28'd0, key_code}, 32'd15);

    // Letter A keeps digits
    press(2, 0, 40);
    press(0, 3, 40);
    check_val("letter_code", {28'd0, key_code}, 32'd10);
    check_val("letter_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0007);

    // Reset just before acceptance of key 9 (row2, col2)
    key_r = 2;
    key_c = 2;
    key_on = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk);
      #1;
      if (col_out == 4'b1011) found = 1'b1;
    end
    check_val("col9_wait", {31'd0, found}, 32'd1);
    // Column selected at edge E; matches at E+4, E+8, acceptance due at E+12.
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    ed = 16'd0;
    repeat (3) @(posedge clk);
    key_on = 1'b0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("restart_col", {28'd0, col_out}, 32'hE);
    repeat (40) @(posedge clk);

    // Scanning works after reset
    press(1, 1, 40);
    check_val("after_reset_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0005);
    check_val("q_final", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_digit_entry.md
# keypad_digit_entry

Scans a 4x4 active-low matrix keypad, debounces presses, and assembles up to four decimal digits into a shifting entry buffer. This is the input-side counterpart of the team's multiplexed four-digit seven-segment display driver. The block time-multiplexes column drive in the same way the display multiplexes digit enables. Its digit3..digit0 outputs connect directly to the display driver's four BCD digit inputs.

## Interface
- SCAN_DIV, default 16'd50000: clock cycles per scan tick; must be at least 4.
- DEBOUNCE, default 4: number of consecutive identical ticks needed to accept a press or a release; must be at least 2.

- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- row_in  input  4  keypad rows, active-low, asynchronous to clk
- col_out  output  4  column drive, active-low one-hot
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_code  output  4  code of the last accepted key; held between presses
- digit3, digit2, digit1, digit0  output  4 each  BCD entry buffer; digit3 is the most significant

## Operation
- **Row synchronisation:** row_in passes through a 2-flop synchroniser. All decisions use the synchronised value, called row_s.
- **Tick generation:** a free-running divider asserts tick for 1 cycle every SCAN_DIV cycles.
- **Key map (row r, column c):**
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *, 0, #, D
  - key_code values: digits 0–9 map to 0–9; A=10, B=11, C=12, D=13, *=14, #=15.
- **Multiple rows low:** if more than one row is low, the lowest-index low row selects the key. The full 4-bit row_s pattern is what gets compared for debounce.
- **FSM states: SCAN, DEBOUNCE, HELD.**
  - **SCAN, on tick:**
    - If row_s is all high, rotate col_out to the next column (c0→c1→c2→c3→c0).
    - Otherwise, freeze the column, latch the pattern, set match count = 1, and go to DEBOUNCE.
  - **DEBOUNCE, on tick:**
    - If row_s equals the latched pattern, increment the count. When the count reaches DEBOUNCE, accept the key and go to HELD.
    - If row_s differs (including all high), go to SCAN and rotate the column.
  - **HELD:** the column stays frozen. On each tick, count consecutive all-high samples; any non-high sample resets this count to 0. When DEBOUNCE consecutive all-high ticks are seen, go to SCAN and rotate the column.
- **Actions on accepting a key:**
  - key_code is loaded and key_valid pulses.
  - Digit key k: {digit3..digit0} ← {digit2, digit1, digit0, k}.
  - * (backspace): {digit3..digit0} ← {0, digit3, digit2, digit1}.
  - # (clear): all digits ← 0.
  - A–D: digits are unchanged, but key_valid still pulses.
- **Pulse limit:** exactly one key_valid per physical press. A held key never repeats.
- **Frozen-column behaviour:** keys in other columns are invisible while the column is frozen.

## Timing
- **Reset values:**
  - col_out = 4'b1110
  - key_valid = 0, key_code = 0
  - digit3..digit0 = 0
  - FSM = SCAN; divider, debounce counters and synchroniser flops all 0
  - Synchroniser flops reset to 0, so row_s reads all low for the first 2 cycles after rst deasserts. Because the first tick occurs SCAN_DIV (≥4) cycles after reset, this value is never sampled.
- **Column settling:** col_out changes only on the tick edge. The row for that column is first sampled SCAN_DIV cycles later.
- **Acceptance timing:** acceptance occurs at the clock edge of the DEBOUNCE-th matching tick.
  - In the following cycle, key_valid is 1, and key_code and the digits already show their new values.
  - key_valid returns to 0 one cycle later.
- **Press latency:** from row_in stable low, worst case is 2 + 4·SCAN_DIV + (DEBOUNCE−1)·SCAN_DIV + 1 cycles.
- **Reset during operation:** asserting rst clears all state immediately, including a pending DEBOUNCE. No key_valid is emitted, even if acceptance would have fallen on the same edge.
- **Release ordering:** a release followed by a new press only begins scanning after HELD exits.
- **Bounce on release:** bounce during release (a low sample in HELD) restarts the release count. It never produces a new key_valid.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3.

- **Single digit:** hold row1 low while col_out=4'b1101 (key 5) for ≥3 ticks → one key_valid, key_code=5, digits 0,0,0,5, col_out frozen at 4'b1101 until release is accepted.
- **Digit sequence:** press 1,2,3,4,5 with clean releases → 5 key_valid pulses; final digits 2,3,4,5.
- **Bounce:** row0 low for 1 tick, then high → no key_valid, FSM back in SCAN, column rotates. Hold key 5 for 40 ticks → exactly 1 key_valid.
- **Backspace and clear:** after digits 1,2,3,4, press * → digits 0,1,2,3, key_code=14. Press # → digits 0,0,0,0, key_code=15.
- **Letter key:** press A (row0, col3) → key_valid, key_code=10, digits unchanged.
- **Reset mid-operation:** assert rst after 2 matching ticks of key 9 → all outputs return to reset values at once, no key_valid. After release of rst, scanning restarts at col_out=4'b1110.
